// File: rtl/wr_resp_buf_pkg.sv
// Shared interconnect definitions for the write-response path.
// Holds the ID width, the BRESP encoding and the default outstanding-write limit.
// Pure declarations; no logic and no latency.
package wr_resp_buf_pkg;

  localparam int ID_W          = 4;
  localparam int RESP_W        = 2;
  localparam int DEF_MAX_OUTST = 8;

  typedef enum logic [RESP_W-1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } bresp_e;

  // One buffered B beat: {bid, bresp}
  typedef struct packed {
    logic [ID_W-1:0]   bid;
    logic [RESP_W-1:0] bresp;
  } b_ent_t;

  // SLVERR and DECERR are the two error responses
  function automatic logic is_err_resp(input logic [RESP_W-1:0] r);
    return (r == RESP_SLVERR) || (r == RESP_DECERR);
  endfunction

endpackage

// File: rtl/wr_resp_fifo.sv
// Generic first-word-fall-through synchronous FIFO, DEPTH entries of W bits.
// Latency: a write is visible on rd_vld/rd_dat the cycle after it is accepted.
// Backpressure: wr_rdy = !full from registered pointers; no write when full, even with a read.
module wr_resp_fifo
  import wr_resp_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = $bits(b_ent_t)
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         wr_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  input  logic         rd_rdy
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [W-1:0] mem [DEPTH];
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;

  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign wr_rdy = !full;
  assign rd_vld = !empty;
  assign push   = wr_vld && !full;
  assign pop    = rd_rdy && !empty;

  // Head entry falls through; forced to zero while empty so reset shows clean outputs
  assign rd_dat = empty ? '0 : mem[rptr[AW-1:0]];

  // Pointer advance; reset discards any buffered beats
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents are left unreset since the pointers gate visibility
  always_ff @(posedge aclk) begin
    if (push) mem[wptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/wr_resp_buf.sv
// Master-side B-response buffer with outstanding-write tracking and sticky error flags.
// Latency: one cycle from an accepted bvalid_s beat to bvalid_m; no combinational bypass.
// Backpressure: bready_s drops when the FIFO is full; aw_block asserts at the outstanding limit.
module wr_resp_buf
  import wr_resp_buf_pkg::*;
#(
  parameter  int DEPTH     = 4,
  parameter  int MAX_OUTST = DEF_MAX_OUTST,
  localparam int CW        = $clog2(MAX_OUTST + 1)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ID_W-1:0]   bid_s,
  input  logic [RESP_W-1:0] bresp_s,
  input  logic              bvalid_s,
  output logic              bready_s,
  output logic [ID_W-1:0]   bid_m,
  output logic [RESP_W-1:0] bresp_m,
  output logic              bvalid_m,
  input  logic              bready_m,
  input  logic              aw_fire,
  output logic [CW-1:0]     outst_cnt,
  output logic              aw_block,
  output logic              resp_err,
  output logic              unexp_b
);

  b_ent_t in_ent;
  b_ent_t out_ent;
  logic   pop;

  assign in_ent  = {bid_s, bresp_s};
  assign bid_m   = out_ent.bid;
  assign bresp_m = out_ent.bresp;
  assign pop     = bvalid_m && bready_m;

  wr_resp_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(b_ent_t))
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .wr_vld  (bvalid_s),
    .wr_dat  (in_ent),
    .wr_rdy  (bready_s),
    .rd_vld  (bvalid_m),
    .rd_dat  (out_ent),
    .rd_rdy  (bready_m)
  );

  assign aw_block = (outst_cnt == CW'(MAX_OUTST));

  // Outstanding count: AW and B in the same cycle cancel, even at the limit
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      outst_cnt <= '0;
    end else if (aw_fire && pop) begin
      outst_cnt <= outst_cnt;
    end else if (aw_fire && !aw_block) begin
      outst_cnt <= outst_cnt + 1'b1;
    end else if (pop && (outst_cnt != '0)) begin
      outst_cnt <= outst_cnt - 1'b1;
    end
  end

  // Sticky flags: error response delivered, or a B delivered with nothing outstanding
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      resp_err <= 1'b0;
      unexp_b  <= 1'b0;
    end else begin
      if (pop && is_err_resp(bresp_m))                 resp_err <= 1'b1;
      if (pop && (outst_cnt == '0) && !aw_fire)        unexp_b  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wr_resp_buf.sv
// Bench for wr_resp_buf: directed scenarios plus a randomized run.
// A queue-based reference model predicts every buffered beat and counter/flag value.
// A negedge monitor compares all DUT outputs against the model each cycle.
module tb_wr_resp_buf;
  import wr_resp_buf_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 8;

  logic       aclk;
  logic       aresetn;
  logic [3:0] bid_s;
  logic [1:0] bresp_s;
  logic       bvalid_s;
  logic       bready_s;
  logic [3:0] bid_m;
  logic [1:0] bresp_m;
  logic       bvalid_m;
  logic       bready_m;
  logic       aw_fire;
  logic [3:0] outst_cnt;
  logic       aw_block;
  logic       resp_err;
  logic       unexp_b;

  int tests = 0;
  int fails = 0;

  // Reference model state
  b_ent_t exp_q[$];
  int     m_cnt   = 0;
  bit     m_err   = 0;
  bit     m_unexp = 0;

  wr_resp_buf #(.DEPTH(DEPTH), .MAX_OUTST(MAXO)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .bid_s     (bid_s),
    .bresp_s   (bresp_s),
    .bvalid_s  (bvalid_s),
    .bready_s  (bready_s),
    .bid_m     (bid_m),
    .bresp_m   (bresp_m),
    .bvalid_m  (bvalid_m),
    .bready_m  (bready_m),
    .aw_fire   (aw_fire),
    .outst_cnt (outst_cnt),
    .aw_block  (aw_block),
    .resp_err  (resp_err),
    .unexp_b   (unexp_b)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a bounded queue of beats, a saturating counter, two sticky bits
  always @(posedge aclk or negedge aresetn) begin
    int  occ;
    bit  do_pop;
    bit  do_push;
    if (!aresetn) begin
      exp_q.delete();
      m_cnt   = 0;
      m_err   = 0;
      m_unexp = 0;
    end else begin
      occ     = exp_q.size();
      do_pop  = (occ > 0) && bready_m;
      do_push = bvalid_s && (occ < DEPTH);
      if (do_pop) begin
        if (exp_q[0].bresp >= 2) m_err = 1;
        if (m_cnt == 0 && !aw_fire) m_unexp = 1;
      end
      if (aw_fire && do_pop) m_cnt = m_cnt;
      else if (aw_fire)      m_cnt = (m_cnt < MAXO) ? m_cnt + 1 : MAXO;
      else if (do_pop)       m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back('{bid: bid_s, bresp: bresp_s});
    end
  end

  // Monitor: every cycle out of reset, DUT outputs must match the model
  always @(negedge aclk) begin
    if (aresetn) begin
      chk("mon_bvalid_m", bvalid_m, exp_q.size() != 0);
      chk("mon_bready_s", bready_s, exp_q.size() < DEPTH);
      if (exp_q.size() != 0) begin
        chk("mon_bid_m",   bid_m,   exp_q[0].bid);
        chk("mon_bresp_m", bresp_m, exp_q[0].bresp);
      end
      chk("mon_outst_cnt", outst_cnt, m_cnt);
      chk("mon_aw_block",  aw_block,  m_cnt == MAXO);
      chk("mon_resp_err",  resp_err,  m_err);
      chk("mon_unexp_b",   unexp_b,   m_unexp);
    end
  end

  // Drive one cycle of inputs; returns 1 time unit after the consuming edge
  task automatic step(input logic bv, input logic [3:0] id, input logic [1:0] rs,
                      input logic br, input logic aw);
    bvalid_s = bv;
    bid_s    = id;
    bresp_s  = rs;
    bready_m = br;
    aw_fire  = aw;
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input logic br);
    step(1'b0, 4'h0, 2'b00, br, 1'b0);
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    bvalid_s = 1'b0;
    bid_s    = '0;
    bresp_s  = '0;
    bready_m = 1'b0;
    aw_fire  = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    // Reset values observed while reset is held
    aresetn = 1'b0;
    #1;
    chk("rst_bvalid_m",  bvalid_m,  0);
    chk("rst_bready_s",  bready_s,  1);
    chk("rst_outst_cnt", outst_cnt, 0);
    chk("rst_aw_block",  aw_block,  0);
    chk("rst_resp_err",  resp_err,  0);
    chk("rst_unexp_b",   unexp_b,   0);
    chk("rst_bid_m",     bid_m,     0);
    chk("rst_bresp_m",   bresp_m,   0);
    do_reset();

    // Fill and drain
    repeat (3) step(1'b0, 4'h0, 2'b00, 1'b0, 1'b1);
    chk("fill_cnt3", outst_cnt, 3);
    step(1'b1, 4'h5, RESP_OKAY, 1'b0, 1'b0);
    chk("fill_lat1_vld", bvalid_m, 1);
    chk("fill_head",     bid_m,    4'h5);
    step(1'b1, 4'h6, RESP_EXOKAY, 1'b0, 1'b0);
    step(1'b1, 4'h7, RESP_OKAY,   1'b0, 1'b0);
    chk("fill_hold_head", bid_m, 4'h5);
    bvalid_s = 1'b0;
    bready_m = 1'b1;
    #1;
    chk("drain_0", bid_m, 4'h5);
    @(posedge aclk); #1;
    chk("drain_1", bid_m, 4'h6);
    @(posedge aclk); #1;
    chk("drain_2", bid_m, 4'h7);
    @(posedge aclk); #1;
    chk("drain_empty", bvalid_m, 0);
    chk("drain_cnt0",  outst_cnt, 0);

    // Full backpressure
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), RESP_OKAY, 1'b0, 1'b0);
    chk("full_rdy_low", bready_s, 0);
    step(1'b1, 4'h9, RESP_OKAY, 1'b0, 1'b0);
    chk("full_held", bready_s, 0);
    step(1'b1, 4'h9, RESP_OKAY, 1'b1, 1'b0);
    chk("full_pop_rdy", bready_s, 1);
    chk("full_pop_head", bid_m, 4'h2);
    step(1'b1, 4'h9, RESP_OKAY, 1'b0, 1'b0);
    chk("full_fifth_in", bready_s, 0);
    repeat (DEPTH + 1) idle(1'b1);

    // Simultaneous push/pop at occupancy two
    do_reset();
    step(1'b1, 4'hA, RESP_OKAY, 1'b0, 1'b0);
    step(1'b1, 4'hB, RESP_OKAY, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'(i), RESP_EXOKAY, 1'b1, 1'b0);
      chk("simul_vld", bvalid_m, 1);
      chk("simul_rdy", bready_s, 1);
    end
    repeat (3) idle(1'b1);
    chk("simul_drained", bvalid_m, 0);

    // Counter limit
    do_reset();
    repeat (8) step(1'b0, 4'h0, 2'b00, 1'b0, 1'b1);
    chk("lim_block", aw_block, 1);
    chk("lim_cnt8",  outst_cnt, 8);
    step(1'b0, 4'h0, 2'b00, 1'b0, 1'b1);
    chk("lim_sat", outst_cnt, 8);
    step(1'b1, 4'h3, RESP_OKAY, 1'b0, 1'b0);
    step(1'b0, 4'h0, 2'b00, 1'b1, 1'b1);
    chk("lim_pop_aw", outst_cnt, 8);
    chk("lim_pop_aw_blk", aw_block, 1);

    // Sticky flags
    do_reset();
    step(1'b0, 4'h0, 2'b00, 1'b0, 1'b1);
    step(1'b1, 4'h9, RESP_DECERR, 1'b0, 1'b0);
    idle(1'b1);
    chk("flag_err",      resp_err,  1);
    chk("flag_err_cnt0", outst_cnt, 0);
    chk("flag_no_unexp", unexp_b,   0);
    step(1'b1, 4'h3, RESP_OKAY, 1'b0, 1'b0);
    idle(1'b1);
    chk("flag_unexp",   unexp_b,   1);
    chk("flag_unexp_cnt", outst_cnt, 0);
    repeat (3) idle(1'b0);
    chk("flag_err_keep",   resp_err, 1);
    chk("flag_unexp_keep", unexp_b,  1);

    // Mid-operation asynchronous reset
    do_reset();
    step(1'b0, 4'h0, 2'b00, 1'b0, 1'b1);
    step(1'b0, 4'h0, 2'b00, 1'b0, 1'b1);
    step(1'b1, 4'h1, RESP_OKAY, 1'b0, 1'b0);
    step(1'b1, 4'h2, RESP_OKAY, 1'b0, 1'b0);
    bvalid_s = 1'b0;
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst_bvalid_m",  bvalid_m,  0);
    chk("arst_bready_s",  bready_s,  1);
    chk("arst_outst_cnt", outst_cnt, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    idle(1'b0);
    bvalid_s = 1'b1;
    bid_s    = 4'hC;
    bresp_s  = RESP_SLVERR;
    #1;
    chk("arst_no_bypass", bvalid_m, 0);
    @(posedge aclk); #1;
    chk("arst_lat1_vld", bvalid_m, 1);
    chk("arst_lat1_bid", bid_m, 4'hC);
    repeat (3) idle(1'b1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 35));
    end
    repeat (DEPTH + 2) idle(1'b1);
    chk("rand_drained", bvalid_m, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wr_resp_buf.md
WR_RESP_BUF -- requirements
Module: wr_resp_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning B-response FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter MAX_OUTST, default 8, meaning maximum outstanding writes per master.
REQ-003 SHALL have port aclk, input, 1, meaning the single clock; all state on rising edge.
REQ-004 SHALL have port aresetn, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port bid_s, input, 4, meaning the B ID from the write-response mux (upstream).
REQ-006 SHALL have port bresp_s, input, 2, meaning the B response from the mux.
REQ-007 SHALL have port bvalid_s, input, 1, meaning B valid from the mux.
REQ-008 SHALL have port bready_s, output, 1, meaning B ready to the mux.
REQ-009 SHALL have port bid_m, output, 4, meaning the B ID to the master.
REQ-010 SHALL have port bresp_m, output, 2, meaning the B response to the master.
REQ-011 SHALL have port bvalid_m, output, 1, meaning B valid to the master.
REQ-012 SHALL have port bready_m, input, 1, meaning B ready from the master.
REQ-013 SHALL have port aw_fire, input, 1, meaning the master AW handshake completed this cycle.
REQ-014 SHALL have port outst_cnt, output, clog2(MAX_OUTST+1) (default 4), meaning the outstanding write count.
REQ-015 SHALL have port aw_block, output, 1, meaning the AW gate request, high when outst_cnt==MAX_OUTST.
REQ-016 SHALL have port resp_err, output, 1, meaning a sticky flag for an SLVERR/DECERR delivered to the master.
REQ-017 SHALL have port unexp_b, output, 1, meaning a sticky flag for a B delivered with no outstanding write.

Function
REQ-018 SHALL operate the FIFO first-word-fall-through: bvalid_m=!empty; bid_m/bresp_m=head entry.
REQ-019 SHALL drive bready_s=!full; push=bvalid_s&bready_s; pop=bvalid_m&bready_m.
REQ-020 SHALL have push-to-bvalid_m latency of 1 cycle when empty; no combinational bypass from bvalid_s to bvalid_m.
REQ-021 SHALL not push when full, including a cycle with a simultaneous pop; bready_s depends only on registered state.
REQ-022 SHALL, on simultaneous push and pop when neither full nor empty, leave occupancy unchanged and preserve order.
REQ-023 SHALL wrap read/write pointers modulo DEPTH, with full and empty distinguished by an extra pointer bit or an occupancy count.
REQ-024 SHALL hold bid_m/bresp_m stable while bvalid_m=1 and bready_m=0.
REQ-025 SHALL increment outst_cnt on aw_fire and decrement it on pop; both in one cycle leaves it unchanged.
REQ-026 SHALL saturate outst_cnt at MAX_OUTST (aw_fire while aw_block is ignored) and at 0.
REQ-027 SHALL set unexp_b on a pop with outst_cnt==0 and no aw_fire in that cycle; the count stays 0.
REQ-028 SHALL set resp_err on a pop with bresp_m[1]==1; both flags clear only on reset.
REQ-029 SHALL drive aw_block combinationally from registered outst_cnt.

Reset
REQ-030 SHALL, with aresetn low, asynchronously force: FIFO empty, bvalid_m=0, bready_s=1, outst_cnt=0, aw_block=0, resp_err=0, unexp_b=0; bid_m/bresp_m=0.
REQ-031 SHALL discard FIFO contents on reset mid-operation; the first push after aresetn rises behaves as from empty.
REQ-032 SHALL leave FIFO storage arrays unreset; only pointers, counters and flags are reset.

Structure
REQ-033 SHALL take from the shared interconnect package: ID width 4, BRESP codes OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11, and the default outstanding limit.
REQ-034 SHALL instantiate one sub-module, wr_resp_fifo (6-bit-wide {bid,bresp} FWFT sync FIFO, DEPTH entries); counter and flags live in wr_resp_buf.

Verification
REQ-035 SHALL verify fill and drain: 3 aw_fire, then push bid 4'h5/OKAY, 4'h6/EXOKAY, 4'h7/OKAY with bready_m=0 -> bvalid_m=1 one cycle after first push, head 4'h5; bready_m=1 -> 5,6,7 in order; outst_cnt 3->0.
REQ-036 SHALL verify full backpressure: DEPTH=4, bready_m=0, 5 pushes offered -> bready_s=0 after 4th accept; 5th held; one pop -> 5th accepted next cycle.
REQ-037 SHALL verify simultaneous push/pop at 2 entries for 10 cycles -> occupancy 2 throughout, output order = input order.
REQ-038 SHALL verify the counter limit: 8 aw_fire -> aw_block=1, outst_cnt=8; 9th aw_fire -> still 8; one pop with aw_fire same cycle -> 8.
REQ-039 SHALL verify flags: pop DECERR with outst_cnt=1 -> resp_err=1; pop with outst_cnt=0, no aw_fire -> unexp_b=1, outst_cnt=0; both persist.
REQ-040 SHALL verify mid-operation reset: 2 entries held, aresetn low asynchronously -> bvalid_m=0, bready_s=1, outst_cnt=0 immediately; post-reset push has 1-cycle latency.
